coherence_bus_ctrl: RTL
=======================

COHERENCE_BUS_CTRL -- requirements
Module: coherence_bus_ctrl

Interface
REQ-001 Parameter NCPUS, default 2, number of snooping data caches on the bus (2..8).
REQ-002 Parameter SNOOP_TMO, default 15, maximum SNOOP cycles before the snoop is treated as a clean miss.
REQ-003 CLK  in  1  clock; all state updates on the rising edge.
REQ-004 nRST  in  1  reset, asynchronous, active-low.
REQ-005 dREN, dWEN, ccwrite, cctrans  in  NCPUS each  per-cache request/response strobes.
REQ-006 daddr, dstore  in  NCPUS x word_t  per-cache address and store data.
REQ-007 dwait, ccwait, ccinv  out  NCPUS each  per-cache data wait, snoop-hold and invalidate strobes.
REQ-008 dload, ccsnoopaddr  out  NCPUS x word_t  per-cache returned data and snoop address.
REQ-009 mem_ren, mem_wen  out  1 each  memory read/write strobes.
REQ-010 mem_addr, mem_store  out  word_t each  memory address and write data.
REQ-011 mem_load  in  word_t  memory read data.
REQ-012 mem_wait  in  1  memory busy; the access completes in the first cycle mem_wait=0.

Function
REQ-013 Request decode per cache i:
- dWEN[i]: WB (writeback).
- dREN[i]&!ccwrite[i]: BusRd.
- dREN[i]&ccwrite[i]: BusRdX.
- cctrans[i]&!dREN[i]&!dWEN[i]: BusUpgr.
- WB outranks the others within one cache.
REQ-014 Arbitration is round-robin: scan starts at (last_grant+1) mod NCPUS and the first requester wins; last_grant resets to NCPUS-1, so cache 0 wins first.
REQ-015 FSM states: IDLE, ARB, SNOOP, C2C, MEM_RD, MEM_WB, INV, DONE.
REQ-016 IDLE->ARB when any request is present; grant index g and opcode are latched in ARB.
REQ-017 ARB->MEM_WB for WB; otherwise ->SNOOP.
REQ-018 SNOOP behaviour:
- ccwait[j]=1 and ccsnoopaddr[j]=daddr[g] for all j!=g.
- ccwait[g]=0.
REQ-019 SNOOP exit: next cycle after any j!=g has cctrans[j]=1, or after SNOOP_TMO cycles.
- If any such j has ccwrite[j]=1 (dirty supplier; lowest index wins): ->C2C.
- Else BusUpgr ->INV; BusRd/BusRdX ->MEM_RD.
REQ-020 C2C behaviour:
- Latches dstore[j] as return data.
- Drives mem_wen=1, mem_addr=daddr[g], mem_store=dstore[j] until mem_wait=0 (memory update on flush).
- Then ->INV for BusRdX, ->DONE for BusRd.
REQ-021 MEM_RD: mem_ren=1, mem_addr=daddr[g]; mem_load is captured when mem_wait=0, then ->INV (BusRdX) or ->DONE.
REQ-022 MEM_WB: mem_wen=1, mem_addr=daddr[g], mem_store=dstore[g]; ->DONE when mem_wait=0.
REQ-023 INV: ccinv[j]=1 for exactly one cycle for all j!=g; ->DONE.
REQ-024 DONE: dwait[g]=0 and dload[g]=captured data (0 for WB/BusUpgr) for exactly one cycle; ccwait all 0; ->IDLE.
REQ-025 dwait[i]=1 in every cycle except the DONE cycle for i=g; last_grant=g updates in DONE.
REQ-026 Only one transaction is in flight. Requests arriving mid-transaction wait; simultaneous requests resolve by REQ-014, so every cache is served within NCPUS transactions.
REQ-027 A requester that drops its request before DONE still completes the latched transaction.
REQ-028 mem_ren and mem_wen are never both 1 in the same cycle.

Reset
REQ-029 Reset values:
- dwait all 1; ccwait, ccinv, dload and ccsnoopaddr all 0.
- mem_ren, mem_wen, mem_addr and mem_store 0.
- State IDLE; timeout counter 0.
REQ-030 Reset mid-transaction aborts it; no memory strobe survives reset.

Structure
REQ-031 word_t comes from cpu_types_pkg.
REQ-032 The bus state enum and bus opcode enum (WB, BUSRD, BUSRDX, BUSUPGR) are added to cpu_types_pkg.
REQ-033 Round-robin arbitration is one sub-module, rr_arbiter (parameter N; ports req, last, gnt_idx, gnt_valid); all other logic stays in coherence_bus_ctrl.

Verification
REQ-034 Directed scenarios:
- NCPUS=2, cache0 BusRd 0x100, no dirty supplier, mem_wait=0 after 3 cycles, mem_load=0xDEAD -> dload[0]=0xDEAD, dwait[0] low for 1 cycle, mem_wen never 1.
- NCPUS=4, cache2 BusRdX 0x200, cache1 responds cctrans=1, ccwrite=1, dstore=0xBEEF -> dload[2]=0xBEEF, memory written 0xBEEF@0x200, ccinv=4'b1011 for one cycle.
- NCPUS=2, cache1 BusUpgr 0x300 -> ccinv[0] pulses one cycle, dload[1]=0, no memory strobes.
- NCPUS=4, all caches request continuously -> grant order 0,1,2,3,0.
- No snoop response for SNOOP_TMO=15 cycles -> MEM_RD entered at cycle 16.
- nRST low during MEM_WB -> mem_wen=0 immediately, dwait=all 1, state IDLE.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the CPU / cache / bus codebase.
//   word_t      - 32-bit machine word used for addresses and data
//   bus_state_t - coherence bus controller FSM states
//   bus_op_t    - decoded bus transaction opcode
//   decode_op   - per-cache request decode (writeback outranks the rest)
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE, ARB, SNOOP, C2C, MEM_RD, MEM_WB, INV, DONE
    } bus_state_t;

    typedef enum logic [1:0] {
        WB, BUSRD, BUSRDX, BUSUPGR
    } bus_op_t;

    function automatic bus_op_t decode_op(input logic wen, input logic ren, input logic ccw);
        if (wen)      return WB;
        else if (ren) return ccw ? BUSRDX : BUSRD;
        else          return BUSUPGR;
    endfunction

endpackage

// File: rtl/coherence_bus_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req       in  N       request vector
//   last      in  log2(N) index granted last time
//   gnt_idx   out log2(N) winning index
//   gnt_valid out 1       at least one request present
// The scan starts one past 'last' and wraps; the first requester wins.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_valid
);
    localparam int IW = $clog2(N);

    // Walk the scan order backwards so the nearest requester is written last.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last) + k) % N]) begin
                gnt_idx   = IW'((int'(last) + k) % N);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: snooping MSI-style bus controller for NCPUS data caches
// sharing one memory port. One transaction in flight at a time.
//   CLK, nRST                         clock, async active-low reset
//   dREN/dWEN/ccwrite/cctrans [NCPUS] per-cache request / snoop-response strobes
//   daddr/dstore [NCPUS]              per-cache address and store data
//   dwait/ccwait/ccinv [NCPUS]        data wait, snoop hold, invalidate
//   dload/ccsnoopaddr [NCPUS]         returned data, snoop address
//   mem_ren/mem_wen/mem_addr/mem_store, mem_load/mem_wait  memory port
//   dbg_state                          current FSM state (observation only)
// Handshake: a cache presents a request and may hold or drop it; the granted
// cache sees dwait low for exactly one cycle (DONE) with dload valid. A memory
// access completes in the first cycle mem_wait is low.
module coherence_bus_ctrl
    import cpu_types_pkg::*;
#(
    parameter int NCPUS     = 2,
    parameter int SNOOP_TMO = 15
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [NCPUS-1:0]        dREN,
    input  logic [NCPUS-1:0]        dWEN,
    input  logic [NCPUS-1:0]        ccwrite,
    input  logic [NCPUS-1:0]        cctrans,
    input  word_t [NCPUS-1:0]       daddr,
    input  word_t [NCPUS-1:0]       dstore,
    output logic [NCPUS-1:0]        dwait,
    output logic [NCPUS-1:0]        ccwait,
    output logic [NCPUS-1:0]        ccinv,
    output word_t [NCPUS-1:0]       dload,
    output word_t [NCPUS-1:0]       ccsnoopaddr,
    output logic                    mem_ren,
    output logic                    mem_wen,
    output word_t                   mem_addr,
    output word_t                   mem_store,
    input  word_t                   mem_load,
    input  logic                    mem_wait,
    output bus_state_t              dbg_state
);
    localparam int GW = $clog2(NCPUS);
    localparam int TW = $clog2(SNOOP_TMO + 1);

    bus_state_t    state_q, state_d;
    bus_op_t       op_q, op_d;
    logic [GW-1:0] gnt_q, gnt_d;
    logic [GW-1:0] last_q, last_d;
    word_t         data_q, data_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic [NCPUS-1:0] req_vec;
    logic [GW-1:0]    arb_idx;
    logic             arb_valid;
    logic             resp_any, dirty_any;
    logic [GW-1:0]    dirty_idx;

    assign req_vec   = dWEN | dREN | cctrans;
    assign dbg_state = state_q;

    rr_arbiter #(.N(NCPUS)) u_arb (
        .req       (req_vec),
        .last      (last_q),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    // Snoop responses from every cache except the granted one; the lowest
    // dirty responder is chosen as the supplier (reverse walk, last write wins).
    always_comb begin
        resp_any  = 1'b0;
        dirty_any = 1'b0;
        dirty_idx = '0;
        for (int j = NCPUS - 1; j >= 0; j--) begin
            if (j != int'(gnt_q) && cctrans[j]) begin
                resp_any = 1'b1;
                if (ccwrite[j]) begin
                    dirty_any = 1'b1;
                    dirty_idx = GW'(j);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        data_d      = data_q;
        tmo_d       = '0;
        dwait       = '1;
        ccwait      = '0;
        ccinv       = '0;
        dload       = '0;
        ccsnoopaddr = '0;
        mem_ren     = 1'b0;
        mem_wen     = 1'b0;
        mem_addr    = '0;
        mem_store   = '0;
        case (state_q)
            IDLE: if (|req_vec) state_d = ARB;
            ARB: begin
                if (arb_valid) begin
                    gnt_d   = arb_idx;
                    op_d    = decode_op(dWEN[arb_idx], dREN[arb_idx], ccwrite[arb_idx]);
                    data_d  = '0;
                    state_d = dWEN[arb_idx] ? MEM_WB : SNOOP;
                end else begin
                    state_d = IDLE;   // requester vanished before the grant
                end
            end
            SNOOP: begin
                for (int j = 0; j < NCPUS; j++) begin
                    if (j != int'(gnt_q)) begin
                        ccwait[j]      = 1'b1;
                        ccsnoopaddr[j] = daddr[gnt_q];
                    end
                end
                tmo_d = tmo_q + 1'b1;
                if (resp_any && dirty_any) begin
                    data_d  = dstore[dirty_idx];   // return data from the supplier
                    state_d = C2C;
                end else if (resp_any || tmo_q == TW'(SNOOP_TMO - 1)) begin
                    state_d = (op_q == BUSUPGR) ? INV : MEM_RD;
                end
            end
            C2C: begin
                // Supplier's dirty line is flushed back to memory as it is forwarded.
                mem_wen   = 1'b1;
                mem_addr  = daddr[gnt_q];
                mem_store = data_q;
                if (!mem_wait) state_d = (op_q == BUSRDX) ? INV : DONE;
            end
            MEM_RD: begin
                mem_ren  = 1'b1;
                mem_addr = daddr[gnt_q];
                if (!mem_wait) begin
                    data_d  = mem_load;
                    state_d = (op_q == BUSRDX) ? INV : DONE;
                end
            end
            MEM_WB: begin
                mem_wen   = 1'b1;
                mem_addr  = daddr[gnt_q];
                mem_store = dstore[gnt_q];
                if (!mem_wait) state_d = DONE;
            end
            INV: begin
                for (int j = 0; j < NCPUS; j++) begin
                    if (j != int'(gnt_q)) ccinv[j] = 1'b1;
                end
                state_d = DONE;
            end
            DONE: begin
                dwait[gnt_q] = 1'b0;
                dload[gnt_q] = data_q;
                last_d       = gnt_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            op_q    <= WB;
            gnt_q   <= '0;
            last_q  <= GW'(NCPUS - 1);   // cache 0 wins the first arbitration
            data_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule
